alu_issue_stage: RTL and testbench

Execute-stage initiator for the shared 32-bit ALU. It accepts decoded instruction fields over a valid/ready handshake, maps them to the ALU's 4-bit control encoding, and selects operands. It presents registered a/b/alu_ctrl to the ALU, captures alu_out/zero one cycle later, and returns result, branch decision and illegal flag over a second valid/ready handshake. The ALU is instantiated beside this block; this block drives it and consumes its outputs.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/alu_ctrl_decode.sv | 51 +++++
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the ALU issue stage: ALU control encoding, RV32I opcodes,
// branch funct3 values, FSM states and the branch-taken helper.
package riscv_pkg;

    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_W   = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1001;

    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;

    localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // SUB result zero means equal; SLT/SLTU result nonzero means less-than.
    function automatic logic branch_taken(input logic [FUNCT3_W-1:0] f3, input logic zero);
        case (f3)
            F3_BEQ, F3_BGE, F3_BGEU: branch_taken = zero;
            F3_BNE, F3_BLT, F3_BLTU: branch_taken = !zero;
            default:                 branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU control and side flags.
module alu_ctrl_decode
    import riscv_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT3_W-1:0]   funct3,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  use_imm,
    output logic                  is_branch,
    output logic                  illegal
);

    always_comb begin
        alu_ctrl  = ALU_ADD;
        use_imm   = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                use_imm = (opcode == OPC_OPIMM);
                case (funct3)
                    3'b000:  alu_ctrl = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE:   alu_ctrl = ALU_SUB;
                    F3_BLT, F3_BGE:   alu_ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu_ctrl = ALU_SLTU;
                    default:          illegal  = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                use_imm = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage initiator: registers ALU operands/control on accept, captures the
// ALU result one cycle later and holds it on a valid/ready output handshake.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT3_W-1:0]   funct3,
    input  logic                  funct7_5,
    input  logic [WIDTH-1:0]      rs1_val,
    input  logic [WIDTH-1:0]      rs2_val,
    input  logic [WIDTH-1:0]      imm,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic                  out_branch,
    output logic                  out_taken,
    output logic                  out_illegal
);

    state_t state_q, state_d;
    logic   accept, capture;

    logic [ALU_CTRL_W-1:0] dec_ctrl;
    logic                  dec_use_imm, dec_branch, dec_illegal;
    logic [WIDTH-1:0]      op_a, op_b;

    logic                  br_q, ill_q;
    logic [FUNCT3_W-1:0]   f3_q;

    alu_ctrl_decode u_decode (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_ctrl  (dec_ctrl),
        .use_imm   (dec_use_imm),
        .is_branch (dec_branch),
        .illegal   (dec_illegal)
    );

    // Illegal instructions still flow, but with zeroed operands so the result is 0.
    assign op_a = dec_illegal ? '0 : rs1_val;
    assign op_b = dec_illegal ? '0 : (dec_use_imm ? imm : rs2_val);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            in_ready = 1'b0;
            accept   = 1'b0;
            capture  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= ALU_ADD;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
            f3_q        <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_branch  <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            out_valid <= (state_d == ST_HOLD);
            if (accept) begin
                alu_a    <= op_a;
                alu_b    <= op_b;
                alu_ctrl <= dec_ctrl;
                br_q     <= dec_branch;
                ill_q    <= dec_illegal;
                f3_q     <= funct3;
            end
            if (capture) begin
                out_result  <= alu_out;
                out_branch  <= br_q;
                out_illegal <= ill_q;
                out_taken   <= br_q && !ill_q && branch_taken(f3_q, alu_zero);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU attached to its ALU port.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_branch, out_taken, out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .imm         (imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_branch  (out_branch),
        .out_taken   (out_taken),
        .out_illegal (out_illegal)
    );

    // The shared ALU that sits beside the block.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0110: alu_out = alu_a >> alu_b[4:0];
            4'b0111: alu_out = alu_a << alu_b[4:0];
            4'b1000: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1001: alu_out = {31'd0, alu_a < alu_b};
            default: alu_out = 32'd0;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_ctrl;
        logic [31:0] exp_res;
        logic        exp_br;
        logic        exp_tk;
        logic        exp_ill;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_val = r1; rs2_val = r2; imm = im;
    endtask

    // Wait (at negedges) for out_valid; returns number of extra negedges waited.
    task automatic wait_valid(input string name, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: out_valid timeout after %0d cycles", name, cycles);
        end
    endtask

    task automatic run_vec(input int i);
        int cyc;
        vec_t v;
        v = vecs[i];
        drive(v.opcode, v.f3, v.f7, v.rs1, v.rs2, v.imm);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(v.exp_ctrl));
        check($sformatf("v%0d alu_a", i), alu_a, v.exp_a);
        check($sformatf("v%0d alu_b", i), alu_b, v.exp_b);
        check($sformatf("v%0d exec out_valid", i), 32'(out_valid), 32'd0);
        wait_valid($sformatf("v%0d", i), cyc);
        check($sformatf("v%0d latency", i), 32'(cyc), 32'd1);
        check($sformatf("v%0d out_result", i), out_result, v.exp_res);
        check($sformatf("v%0d out_branch", i), 32'(out_branch), 32'(v.exp_br));
        check($sformatf("v%0d out_taken", i), 32'(out_taken), 32'(v.exp_tk));
        check($sformatf("v%0d out_illegal", i), 32'(out_illegal), 32'(v.exp_ill));
        @(negedge clk);
        check($sformatf("v%0d post out_valid", i), 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        //         opc    f3    f7  rs1           rs2           imm           a             b             ctrl  result        br tk il
        vecs[0]  = '{7'h33, 3'd0, 1'b1, 32'd5,        32'd7,        32'd0,        32'd5,        32'd7,        4'h1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{7'h13, 3'd5, 1'b1, 32'h80000000, 32'd0,        32'd4,        32'h80000000, 32'd4,        4'h8, 32'hF8000000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{7'h63, 3'd4, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 32'd1,        4'h5, 32'd1,        1'b1, 1'b1, 1'b0};
        vecs[3]  = '{7'h63, 3'd6, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 32'd1,        4'h9, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[4]  = '{7'h63, 3'd0, 1'b0, 32'd3,        32'd3,        32'd0,        32'd3,        32'd3,        4'h1, 32'd0,        1'b1, 1'b1, 1'b0};
        vecs[5]  = '{7'h63, 3'd1, 1'b0, 32'd3,        32'd3,        32'd0,        32'd3,        32'd3,        4'h1, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[6]  = '{7'h63, 3'd5, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd1,        32'hFFFFFFFF, 4'h5, 32'd0,        1'b1, 1'b1, 1'b0};
        vecs[7]  = '{7'h7F, 3'd0, 1'b0, 32'h55,       32'h66,       32'h77,       32'd0,        32'd0,        4'h0, 32'd0,        1'b0, 1'b0, 1'b1};
        vecs[8]  = '{7'h33, 3'd0, 1'b0, 32'h10,       32'h20,       32'd0,        32'h10,       32'h20,       4'h0, 32'h30,       1'b0, 1'b0, 1'b0};
        vecs[9]  = '{7'h13, 3'd0, 1'b1, 32'h0A,       32'h100,      32'd3,        32'h0A,       32'd3,        4'h0, 32'h0D,       1'b0, 1'b0, 1'b0};
        vecs[10] = '{7'h03, 3'd2, 1'b0, 32'h1000,     32'd5,        32'hFFFFFFFC, 32'h1000,     32'hFFFFFFFC, 4'h0, 32'hFFC,      1'b0, 1'b0, 1'b0};
        vecs[11] = '{7'h23, 3'd2, 1'b0, 32'h20,       32'd5,        32'd8,        32'h20,       32'd8,        4'h0, 32'h28,       1'b0, 1'b0, 1'b0};
        vecs[12] = '{7'h33, 3'd1, 1'b0, 32'd1,        32'h24,       32'd0,        32'd1,        32'h24,       4'h7, 32'h10,       1'b0, 1'b0, 1'b0};
        vecs[13] = '{7'h33, 3'd5, 1'b0, 32'h80000000, 32'd4,        32'd0,        32'h80000000, 32'd4,        4'h6, 32'h08000000, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{7'h33, 3'd4, 1'b0, 32'hF0,       32'hFF,       32'd0,        32'hF0,       32'hFF,       4'h4, 32'h0F,       1'b0, 1'b0, 1'b0};
        vecs[15] = '{7'h33, 3'd6, 1'b0, 32'hF0,       32'h0F,       32'd0,        32'hF0,       32'h0F,       4'h3, 32'hFF,       1'b0, 1'b0, 1'b0};
        vecs[16] = '{7'h33, 3'd7, 1'b0, 32'hF0,       32'h3C,       32'd0,        32'hF0,       32'h3C,       4'h2, 32'h30,       1'b0, 1'b0, 1'b0};
        vecs[17] = '{7'h13, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,        4'h5, 32'd1,        1'b0, 1'b0, 1'b0};
        vecs[18] = '{7'h13, 3'd3, 1'b0, 32'd1,        32'd5,        32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'h9, 32'd1,        1'b0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        check("post-reset out_valid", 32'(out_valid), 32'd0);
        check("post-reset alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("post-reset alu_a", alu_a, 32'd0);
        check("post-reset out_result", out_result, 32'd0);
        check("post-reset flags", {29'd0, out_branch, out_taken, out_illegal}, 32'd0);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Backpressure: hold SUB 5-7 for 5 cycles, then same-cycle accept of ADD 0x10+0x20.
        drive(7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp", cyc);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d out_result", k), out_result, 32'hFFFFFFFE);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d alu_ctrl", k), 32'(alu_ctrl), 32'd1);
            @(negedge clk);
        end
        drive(7'h33, 3'd0, 1'b0, 32'h10, 32'h20, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp accept in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp2 exec out_valid", 32'(out_valid), 32'd0);
        check("bp2 alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        check("bp2 out_valid", 32'(out_valid), 32'd1);
        check("bp2 out_result", out_result, 32'h30);
        @(negedge clk);
        check("bp2 drop out_valid", 32'(out_valid), 32'd0);
        check("bp2 idle in_ready", 32'(in_ready), 32'd1);

        // Reset while in EXEC discards the instruction.
        drive(7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst-exec in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rst-exec out_valid", 32'(out_valid), 32'd0);
        check("rst-exec alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst-exec out_result", out_result, 32'd0);
        reset = 1'b0;
        #1;
        check("rst-exec in_ready after", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst-exec stale%0d", k), 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
